std_spram_banked_wrapper: RTL and testbench

STD_SPRAM_BANKED_WRAPPER -- requirements
Module: std_spram_banked_wrapper

---
 rtl/std_spram_banked_wrapper_pkg.sv | 11 +
 rtl/std_spram_banked_wrapper_bank.sv | 44 ++++
 rtl/std_spram_banked_wrapper.sv | 124 ++++++++++++
 tb/tb_std_spram_banked_wrapper.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/std_spram_banked_wrapper_pkg.sv
// Shared constants for the banked single-port RAM wrapper: macro timing trims
// and the response credit limit.
package std_spram_banked_wrapper_pkg;
  localparam logic [1:0] RTSEL      = 2'b10;
  localparam logic [1:0] WTSEL      = 2'b00;
  localparam logic [1:0] CREDIT_LIM = 2'd2;

  function automatic int bw_of(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 0;
  endfunction
endpackage

// File: rtl/std_spram_banked_wrapper_bank.sv
// One single-port bank: hard macro plus clock gate, or a behavioural array
// with bit-masked write and registered read.
module spram_bank
  import std_spram_banked_wrapper_pkg::*;
#(
  parameter int DW    = 256,
  parameter int DEPTH = 256,
  localparam int LAW  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           ceb,
  input  logic           web,
  input  logic [LAW-1:0] a,
  input  logic [DW-1:0]  d,
  input  logic [DW-1:0]  bweb,
  output logic [DW-1:0]  q
);

`ifdef FPGA
`undef SPRAM_MACRO
`endif

`ifdef SPRAM_MACRO
  logic clk_g;

  cell_icg u_icg (.CP(clk), .E(~ceb), .TE(1'b0), .Q(clk_g));

  ts1n_spram #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .CLK(clk_g), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
    .RTSEL(RTSEL), .WTSEL(WTSEL), .Q(q)
  );
`else
  logic [DW-1:0] mem [DEPTH];

  // The chip enable stands in for the gated clock: an idle bank never toggles.
  always_ff @(posedge clk) begin
    if (!ceb) begin
      if (!web) mem[a] <= (mem[a] & bweb) | (d & ~bweb);
      else      q      <= mem[a];
    end
  end
`endif

endmodule

// File: rtl/std_spram_banked_wrapper.sv
// Banked single-port RAM front end: one bank per access, in-order read
// responses through a credit-limited 2-entry FIFO.
module std_spram_banked_wrapper
  import std_spram_banked_wrapper_pkg::*;
#(
  parameter int DW      = 256,
  parameter int DEPTH   = 256,
  parameter int NBANK   = 2,
  parameter int OUT_REG = 1,
  localparam int AW     = $clog2(DEPTH*NBANK),
  localparam int BW     = bw_of(NBANK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [DW-1:0] req_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata
);

  localparam int LAW = $clog2(DEPTH);
  localparam int SW  = (BW > 0) ? BW : 1;

  logic                       accept, rd_acc, pop, push, fifo_pop, fifo_empty;
  logic [SW-1:0]              bsel, bsel_q;
  logic [NBANK-1:0]           bank_ceb;
  logic [NBANK-1:0][DW-1:0]   bank_q;
  logic [DW-1:0]              arrive_d;
  logic                       vld_pipe;
  logic [1:0]                 credit;
  logic [1:0][DW-1:0]         fifo_mem;
  logic                       wptr, rptr;
  logic [1:0]                 occ;

  assign accept    = req_valid & req_ready;
  assign rd_acc    = accept & ~req_we;
  assign pop       = rsp_valid & rsp_ready;
  // A pop this cycle frees a credit, so a full count alone does not stall.
  assign req_ready = ~((credit == CREDIT_LIM) & ~pop);

  if (BW > 0) begin : g_bsel
    assign bsel = req_addr[AW-1 -: BW];
  end else begin : g_bsel1
    assign bsel = '0;
  end

  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    assign bank_ceb[i] = ~(accept && (bsel == SW'(i)));

    spram_bank #(.DW(DW), .DEPTH(DEPTH)) u_bank (
      .clk  (clk),
      .ceb  (bank_ceb[i]),
      .web  (~req_we),
      .a    (req_addr[LAW-1:0]),
      .d    (req_wdata),
      .bweb (~req_wmask),
      .q    (bank_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= 1'b0;
      bsel_q   <= '0;
    end else begin
      vld_pipe <= rd_acc;
      if (rd_acc) bsel_q <= bsel;
    end
  end

  assign arrive_d = bank_q[bsel_q];
  assign fifo_empty = (occ == 2'd0);

  if (OUT_REG != 0) begin : g_oreg
    assign rsp_valid = ~fifo_empty;
    assign rsp_rdata = fifo_mem[rptr];
    assign push      = vld_pipe;
    assign fifo_pop  = pop;
  end else begin : g_bypass
    // Empty FIFO: bank Q goes straight out, and is only stored if not taken.
    assign rsp_valid = ~fifo_empty | vld_pipe;
    assign rsp_rdata = !fifo_empty ? fifo_mem[rptr] : (vld_pipe ? arrive_d : '0);
    assign push      = vld_pipe & ~(fifo_empty & rsp_ready);
    assign fifo_pop  = pop & ~fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= arrive_d;
        wptr           <= ~wptr;
      end
      if (fifo_pop) rptr <= ~rptr;
      case ({push, fifo_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= 2'd0;
    end else begin
      case ({rd_acc, pop})
        2'b10:   credit <= credit + 2'd1;
        2'b01:   credit <= credit - 2'd1;
        default: credit <= credit;
      endcase
    end
  end

endmodule

// File: tb/tb_std_spram_banked_wrapper.sv
// Directed bench for std_spram_banked_wrapper at default parameters.
module tb_std_spram_banked_wrapper;
  localparam int DW = 256;
  localparam int AW = 9;

  localparam logic [DW-1:0] ONES  = {DW{1'b1}};
  localparam logic [DW-1:0] PA5   = {32{8'hA5}};
  localparam logic [DW-1:0] LO128 = {{128{1'b0}}, {128{1'b1}}};
  localparam logic [DW-1:0] HI128 = {{128{1'b1}}, {128{1'b0}}};
  localparam logic [DW-1:0] OLD7  = {8{32'h0BAD_0007}};
  localparam logic [DW-1:0] NEW7  = {8{32'h600D_0007}};
  localparam logic [DW-1:0] D10   = {8{32'h1000_0010}};
  localparam logic [DW-1:0] D11   = {8{32'h1100_0011}};
  localparam logic [DW-1:0] D12   = {8{32'h1200_0012}};
  localparam logic [DW-1:0] B0    = {8{32'hB0B0_0005}};
  localparam logic [DW-1:0] B1    = {8{32'hB1B1_0105}};

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_wmask;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  std_spram_banked_wrapper dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    #1 chk1("wr_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1 chk1("rd_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chkd("rst_rdata", rsp_rdata, '0);
    chk2("rst_ceb_idle", dut.bank_ceb, 2'b11);
    @(negedge clk);

    // full-mask write then read: two-cycle latency
    wr(9'd0, PA5, ONES);
    rd(9'd0);
    chk1("lat_cyc1_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk1("lat_cyc2_valid", rsp_valid, 1'b1);
    chkd("lat_cyc2_data", rsp_rdata, PA5);
    @(negedge clk);
    chk1("lat_drained", rsp_valid, 1'b0);

    // partial mask write
    wr(9'd3, ONES, ONES);
    wr(9'd3, '0, LO128);
    rd(9'd3);
    @(negedge clk);
    chk1("mask_valid", rsp_valid, 1'b1);
    chkd("mask_data", rsp_rdata, HI128);
    @(negedge clk);

    // read immediately after write to same address
    wr(9'd7, OLD7, ONES);
    wr(9'd7, NEW7, ONES);
    rd(9'd7);
    @(negedge clk);
    chkd("raw_data", rsp_rdata, NEW7);
    @(negedge clk);

    // back-pressure: third read stalls until a pop
    wr(9'd10, D10, ONES);
    wr(9'd11, D11, ONES);
    wr(9'd12, D12, ONES);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'd10;
    #1 chk1("bp_rd0_ready", req_ready, 1'b1);
    @(negedge clk);
    req_addr = 9'd11;
    #1 chk1("bp_rd1_ready", req_ready, 1'b1);
    @(negedge clk);
    req_addr = 9'd12;
    #1 chk1("bp_rd2_stall", req_ready, 1'b0);
    chk1("bp_valid_hold", rsp_valid, 1'b1);
    chkd("bp_head_d10", rsp_rdata, D10);
    @(negedge clk);
    chk1("bp_rd2_still_stall", req_ready, 1'b0);
    chkd("bp_head_still_d10", rsp_rdata, D10);
    rsp_ready = 1'b1;
    #1 chk1("bp_ready_on_pop", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chkd("bp_order_d11", rsp_rdata, D11);
    @(negedge clk);
    chkd("bp_order_d12", rsp_rdata, D12);
    @(negedge clk);
    chk1("bp_drained", rsp_valid, 1'b0);

    // alternating banks, idle bank never enabled
    wr(9'd5, B0, ONES);
    wr(9'd261, B1, ONES);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        req_valid = 1'b1; req_we = 1'b0;
        req_addr = (i % 2 == 0) ? 9'd5 : 9'd261;
        #1;
        chk2("alt_ceb", dut.bank_ceb, (i % 2 == 0) ? 2'b10 : 2'b01);
        chk1("alt_ready", req_ready, 1'b1);
      end else begin
        req_valid = 1'b0;
        #1 chk2("alt_ceb_idle", dut.bank_ceb, 2'b11);
      end
      if (i >= 2) begin
        chk1("alt_valid", rsp_valid, 1'b1);
        chkd("alt_data", rsp_rdata, ((i - 2) % 2 == 0) ? B0 : B1);
      end
      @(negedge clk);
    end
    chk1("alt_drained", rsp_valid, 1'b0);

    // reset with a read in flight
    rd(9'd0);
    rst = 1'b1;
    #1 chk1("rst_mid_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("post_rst_valid", rsp_valid, 1'b0);
      chk1("post_rst_ready", req_ready, 1'b1);
      @(negedge clk);
    end
    rd(9'd0);
    @(negedge clk);
    chk1("post_rst_rd_valid", rsp_valid, 1'b1);
    chkd("post_rst_rd_data", rsp_rdata, PA5);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
